// File: rtl/mul_border_par_pkg.sv
// Shared types and helpers for the parametrised unary-temporal border multiplier.
// Holds the FSM state encoding and a width-generic bit-reverse.
package mul_border_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BITREV_MAX = 32;
  localparam int BITREV_IW  = $clog2(BITREV_MAX);

  // Reverses the low w bits of v; bits at or above w come back as zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int w);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int k = 0; k < BITREV_MAX; k++) begin
      if (k < w) begin
        r[BITREV_IW'(w - 1 - k)] = v[BITREV_IW'(k)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_border_par_if.sv
// Operand/result bundle between a requester and mul_border_par.
// Operands are sign-magnitude; o_cnt carries the M-bit binary product per lane.
interface mul_border_par_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
);
  localparam int M = WIDTH - 1;

  logic                          i_start;
  logic                          i_clr;
  logic [WIDTH-1:0]              i_data_i;
  logic [LANES-1:0][WIDTH-1:0]   i_data_w;
  logic                          o_busy;
  logic [LANES-1:0]              o_bit;
  logic [LANES-1:0]              o_sign;
  logic [LANES-1:0][M-1:0]       o_cnt;
  logic                          o_done;

  modport master (
    output i_start, i_clr, i_data_i, i_data_w,
    input  o_busy, o_bit, o_sign, o_cnt, o_done
  );

  modport slave (
    input  i_start, i_clr, i_data_i, i_data_w,
    output o_busy, o_bit, o_sign, o_cnt, o_done
  );

endinterface

// File: rtl/mul_border_par_sobol_dim1.sv
// Shared low-discrepancy source: a step counter whose bit-reversal is the
// first Sobol dimension (van der Corput, base 2).
module sobol_dim1
  import mul_border_pkg::*;
#(
  parameter int M = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         enable,
  output logic [M-1:0] seq
);

  logic [M-1:0]            r_step;
  logic [BITREV_MAX-1:0]   w_rev;
  logic                    w_rev_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= '0;
    end else if (clr) begin
      r_step <= '0;
    end else if (enable) begin
      r_step <= r_step + M'(1);
    end
  end

  assign w_rev        = bitrev(BITREV_MAX'(r_step), M);
  assign seq          = w_rev[M-1:0];
  // Upper bits are always zero; folded here only so nothing is left dangling.
  assign w_rev_unused = ^w_rev[BITREV_MAX-1:M];

endmodule

// File: rtl/mul_border_par.sv
// Multi-lane unary-temporal multiplier: one input run of n ones shared by LANES weights.
// Optional sign handling is enabled by defining MUL_BORDER_SIGNED_EN.
module mul_border_par
  import mul_border_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input logic             clk,
  input logic             rst,
  mul_border_par_if.slave bus
);

  localparam int M = WIDTH - 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [M-1:0]      r_dcnt;
  logic [M-1:0]      w_nmag;
  logic [M-1:0]      w_seq;
  logic [LANES-1:0]  w_bit;
  logic [LANES-1:0]  w_wsign;
  logic              w_accept;
  logic              w_run;

  assign w_nmag   = bus.i_data_i[M-1:0];
  assign w_run    = (r_state == RUN);
  // Abort wins over a simultaneous start.
  assign w_accept = (r_state == IDLE) && bus.i_start && !bus.i_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_state_next = (w_nmag == '0) ? DONE : RUN;
      RUN:     if (r_dcnt == M'(1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (bus.i_clr) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dcnt <= '0;
    end else if (bus.i_clr) begin
      r_dcnt <= '0;
    end else if (w_accept) begin
      r_dcnt <= w_nmag;
    end else if (w_run) begin
      r_dcnt <= r_dcnt - M'(1);
    end
  end

  sobol_dim1 #(
    .M(M)
  ) u_sobol (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_accept | bus.i_clr),
    .enable (w_run),
    .seq    (w_seq)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gen_lane
      logic [M-1:0] r_wmag;
      logic [M-1:0] r_cnt;

      assign w_wsign[gi] = bus.i_data_w[gi][WIDTH-1];
      assign w_bit[gi]   = w_run && (r_wmag > w_seq);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wmag <= '0;
          r_cnt  <= '0;
        end else if (w_accept) begin
          r_wmag <= bus.i_data_w[gi][M-1:0];
          r_cnt  <= '0;
        end else if (w_run && !bus.i_clr) begin
          r_cnt  <= r_cnt + M'(w_bit[gi]);
        end
      end

      assign bus.o_cnt[gi] = r_cnt;

`ifdef MUL_BORDER_SIGNED_EN
      logic r_sign;
      // A zero operand gives +0 regardless of the stored sign bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sign <= 1'b0;
        end else if (w_accept) begin
          r_sign <= (bus.i_data_i[WIDTH-1] ^ w_wsign[gi]) && (w_nmag != '0)
                    && (bus.i_data_w[gi][M-1:0] != '0);
        end
      end
      assign bus.o_sign[gi] = r_sign;
`else
      assign bus.o_sign[gi] = 1'b0;
`endif
    end
  endgenerate

`ifndef MUL_BORDER_SIGNED_EN
  logic w_unused_sign;
  assign w_unused_sign = bus.i_data_i[WIDTH-1] ^ (^w_wsign);
`endif

  assign bus.o_bit  = w_bit;
  assign bus.o_busy = (r_state != IDLE);
  assign bus.o_done = (r_state == DONE);

endmodule
